// File: rtl/uart_xmit_gen2_pkg.sv
// Shared types and helpers for the uart_xmit_gen2 transmitter slice.
// Holds the frame state encoding, the legal character widths and the counter-width helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   localparam int DATA_BITS_MIN = 5;
   localparam int DATA_BITS_MAX = 8;

   // Bits needed for a counter that runs 0..n-1 (never narrower than one bit).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_xmit_gen2_if.sv
// Write/status bundle between the UART register decode (master) and the transmitter (slave).
interface uart_xmit_gen2_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          WR;
   logic [31:0]   Din;
   logic          ParityEn;
   logic          ParityOdd;
   logic          TwoStop;
   logic          TxRDY;
   logic          Busy;
   logic          Overrun;
   logic [CW-1:0] Count;
   logic          TxD;

   modport master (
      output WR, Din, ParityEn, ParityOdd, TwoStop,
      input  TxRDY, Busy, Overrun, Count, TxD
   );

   modport slave (
      input  WR, Din, ParityEn, ParityOdd, TwoStop,
      output TxRDY, Busy, Overrun, Count, TxD
   );

endinterface

// File: rtl/uart_xmit_gen2_fifo.sv
// Small synchronous transmit FIFO with occupancy count.
// Read data is presented combinationally from the head so a pop edge can latch it directly.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 4,
   localparam int AW    = cnt_width(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge Clock) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/uart_xmit_gen2.sv
// UART transmitter: FIFO-buffered characters framed with start, optional parity and 1/2 stop bits.
// Frame format is captured when a word is popped, so mode changes only affect later frames.
module uart_xmit_gen2
   import uart_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic              Clock,
   input  logic              Reset,
   uart_xmit_gen2_if.slave   bus
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int TW = cnt_width(CLKS_PER_BIT);
   localparam int BW = cnt_width(DATA_BITS);
   localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BMAX = BW'(DATA_BITS - 1);

   tx_state_e            state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [BW-1:0]        bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 parity_q, parity_d;
   logic                 par_en_q, par_en_d;
   logic                 par_odd_q, par_odd_d;
   logic                 two_stop_q, two_stop_d;
   logic                 txd_q, txd_d;
   logic                 overrun_q, overrun_d;

   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_dout;
   logic [CW-1:0]        fifo_count;
   logic                 bit_end;
   logic                 load;
   logic                 unused_din;

   assign unused_din = ^bus.Din;

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .Clock (Clock),
      .Reset (Reset),
      .push  (bus.WR),
      .pop   (fifo_pop),
      .din   (bus.Din[DATA_BITS-1:0]),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bit_end = (timer_q == TMAX);

   always_comb begin
      state_d    = state_q;
      timer_d    = bit_end ? '0 : timer_q + TW'(1);
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      par_en_d   = par_en_q;
      par_odd_d  = par_odd_q;
      two_stop_d = two_stop_q;
      load       = 1'b0;

      case (state_q)
         IDLE: begin
            timer_d = '0;
            load    = ~fifo_empty;
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               bit_idx_d = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d  = shift_q >> 1;
               parity_d = parity_q ^ shift_q[0];
               if (bit_idx_q == BMAX) begin
                  bit_idx_d = '0;
                  state_d   = par_en_q ? PARITY : STOP;
               end else begin
                  bit_idx_d = bit_idx_q + BW'(1);
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d   = STOP;
               bit_idx_d = '0;
            end
         end
         STOP: begin
            // Chain straight into the next start bit when more data is waiting.
            if (bit_end) begin
               if (two_stop_q && (bit_idx_q == '0)) begin
                  bit_idx_d = BW'(1);
               end else if (!fifo_empty) begin
                  load = 1'b1;
               end else begin
                  state_d   = IDLE;
                  bit_idx_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         state_d    = START;
         timer_d    = '0;
         bit_idx_d  = '0;
         shift_d    = fifo_dout;
         parity_d   = 1'b0;
         par_en_d   = bus.ParityEn;
         par_odd_d  = bus.ParityOdd;
         two_stop_d = bus.TwoStop;
      end
      fifo_pop = load;

      // Line level follows the next state so TxD comes straight from a flop.
      txd_d = 1'b1;
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         PARITY:  txd_d = parity_d ^ par_odd_d;
         default: txd_d = 1'b1;
      endcase

      overrun_d = overrun_q | (bus.WR & fifo_full);
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         parity_q   <= 1'b0;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         two_stop_q <= 1'b0;
         txd_q      <= 1'b1;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         parity_q   <= parity_d;
         par_en_q   <= par_en_d;
         par_odd_q  <= par_odd_d;
         two_stop_q <= two_stop_d;
         txd_q      <= txd_d;
         overrun_q  <= overrun_d;
      end
   end

   assign bus.TxD     = txd_q;
   assign bus.TxRDY   = ~fifo_full;
   assign bus.Busy    = (state_q != IDLE) | (fifo_count != '0);
   assign bus.Overrun = overrun_q;
   assign bus.Count   = fifo_count;

endmodule

// File: tb/tb_uart_xmit_gen2.sv
// Bench for uart_xmit_gen2: an 8-bit and a 7-bit instance, each followed cycle by cycle
// by a queue-and-bit-list reference model, plus hand-computed frame vectors and corner sequences.
module tb_uart_xmit_gen2;

   localparam int C     = 4;
   localparam int DEPTH = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   always #5 clk = ~clk;

   uart_xmit_gen2_if #(.FIFO_DEPTH(DEPTH)) b0 ();
   uart_xmit_gen2_if #(.FIFO_DEPTH(DEPTH)) b1 ();

   uart_xmit_gen2 #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(C)) dut0 (
      .Clock (clk),
      .Reset (rst_n),
      .bus   (b0)
   );

   uart_xmit_gen2 #(.DATA_BITS(7), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(C)) dut1 (
      .Clock (clk),
      .Reset (rst_n),
      .bus   (b1)
   );

   // Reference model: pending words, current frame as a list of line levels.
   logic [7:0] m_mem [2][DEPTH];
   int         m_head  [2];
   int         m_size  [2];
   int         m_pos   [2];
   int         m_nbits [2];
   bit         m_active[2];
   bit         m_ovr   [2];
   bit         m_bits  [2][16];

   typedef struct {
      int          d;
      logic [31:0] din;
      logic        pen;
      logic        podd;
      logic        two;
      int          nbits;
      logic [15:0] line;   // line levels in send order, first bit at [nbits-1]
   } vec_t;

   vec_t vecs [4];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic set_mode(input int d, input logic pen, input logic podd, input logic two);
      if (d == 0) begin
         b0.ParityEn = pen; b0.ParityOdd = podd; b0.TwoStop = two;
      end else begin
         b1.ParityEn = pen; b1.ParityOdd = podd; b1.TwoStop = two;
      end
   endtask

   task automatic set_wr(input int d, input logic wr, input logic [31:0] din);
      if (d == 0) begin
         b0.WR = wr; b0.Din = din;
      end else begin
         b1.WR = wr; b1.Din = din;
      end
   endtask

   task automatic get_in(input int d, output logic wr, output logic [31:0] din,
                         output logic pen, output logic podd, output logic two);
      if (d == 0) begin
         wr = b0.WR; din = b0.Din; pen = b0.ParityEn; podd = b0.ParityOdd; two = b0.TwoStop;
      end else begin
         wr = b1.WR; din = b1.Din; pen = b1.ParityEn; podd = b1.ParityOdd; two = b1.TwoStop;
      end
   endtask

   // {TxD, TxRDY, Busy, Overrun, Count[2:0]}
   function automatic logic [6:0] dut_out(input int d);
      if (d == 0) return {b0.TxD, b0.TxRDY, b0.Busy, b0.Overrun, b0.Count};
      else        return {b1.TxD, b1.TxRDY, b1.Busy, b1.Overrun, b1.Count};
   endfunction

   function automatic logic [6:0] model_out(input int d);
      logic txd;
      txd = m_active[d] ? m_bits[d][m_pos[d] / C] : 1'b1;
      return {txd, (m_size[d] < DEPTH), (m_active[d] || (m_size[d] > 0)), m_ovr[d], 3'(m_size[d])};
   endfunction

   task automatic build_frame(input int d, input logic [7:0] w, input int db,
                              input logic pen, input logic podd, input logic two);
      int n;
      n = 0;
      m_bits[d][n] = 1'b0; n++;
      for (int i = 0; i < db; i++) begin
         m_bits[d][n] = w[i]; n++;
      end
      if (pen) begin
         m_bits[d][n] = (($countones(w) % 2) != 0) ^ podd; n++;
      end
      m_bits[d][n] = 1'b1; n++;
      if (two) begin
         m_bits[d][n] = 1'b1; n++;
      end
      m_nbits[d] = n;
   endtask

   task automatic model_step(input int d);
      logic        wr, pen, podd, two;
      logic [31:0] din;
      logic [7:0]  w;
      int          db;
      bit          end_f, do_pop, full;
      get_in(d, wr, din, pen, podd, two);
      db = (d == 0) ? 8 : 7;
      if (!rst_n) begin
         m_size[d] = 0; m_head[d] = 0; m_pos[d] = 0; m_active[d] = 0; m_ovr[d] = 0;
         return;
      end
      end_f  = m_active[d] && (m_pos[d] == m_nbits[d] * C - 1);
      do_pop = (m_size[d] > 0) && (!m_active[d] || end_f);
      full   = (m_size[d] == DEPTH);
      if (wr && full) m_ovr[d] = 1'b1;
      if (do_pop) begin
         w = m_mem[d][m_head[d]];
         m_head[d] = (m_head[d] + 1) % DEPTH;
         m_size[d]--;
         build_frame(d, w, db, pen, podd, two);
         m_active[d] = 1'b1;
         m_pos[d] = 0;
      end else if (m_active[d]) begin
         if (end_f) m_active[d] = 1'b0;
         else       m_pos[d]++;
      end
      if (wr && !full) begin
         m_mem[d][(m_head[d] + m_size[d]) % DEPTH] = din[7:0] & 8'((1 << db) - 1);
         m_size[d]++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("cycle%0d_dut%0d", cyc, d), 32'(dut_out(d)), 32'(model_out(d)));
      end
   endtask

   // Counts cycles until Busy falls; expected length is measured from the write edge.
   task automatic wait_idle(input int d, input int start_cyc, input int exp_len, input string name);
      logic [6:0] o;
      int n;
      n = 0;
      o = dut_out(d);
      while (o[4] && n < 3000) begin
         tick();
         n++;
         o = dut_out(d);
      end
      if (n >= 3000) chk({name, "_timeout"}, 32'(1), 32'(0));
      chk(name, 32'(cyc - start_cyc - 1), 32'(exp_len));
   endtask

   initial begin
      logic [6:0] o;
      int         d, st;

      vecs[0] = '{0, 32'h0000_00A5, 1'b1, 1'b0, 1'b0, 11, 16'b00000_01010010101};
      vecs[1] = '{0, 32'h0000_003C, 1'b0, 1'b0, 1'b1, 11, 16'b00000_00011110011};
      vecs[2] = '{0, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 12, 16'b0000_010000000011};
      vecs[3] = '{1, 32'hFFFF_FFC1, 1'b1, 1'b1, 1'b1, 11, 16'b00000_01000001111};

      for (int k = 0; k < 2; k++) begin
         set_mode(k, 1'b0, 1'b0, 1'b0);
         set_wr(k, 1'b0, 32'h0);
      end
      repeat (3) tick();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("reset_out_dut%0d", k), 32'(dut_out(k)), 32'(7'b1100000));
      end
      rst_n = 1'b1;
      tick();

      // Hand-computed single-frame vectors, line sampled mid-bit.
      for (int k = 0; k < 4; k++) begin
         d = vecs[k].d;
         set_mode(d, vecs[k].pen, vecs[k].podd, vecs[k].two);
         set_wr(d, 1'b1, vecs[k].din);
         tick();
         set_wr(d, 1'b0, 32'h0);
         o = dut_out(d);
         chk($sformatf("vec%0d_count_after_wr", k), 32'(o[2:0]), 32'(1));
         chk($sformatf("vec%0d_txd_after_wr", k), 32'(o[6]), 32'(1));
         tick();
         o = dut_out(d);
         chk($sformatf("vec%0d_start_latency", k), 32'(o[6]), 32'(0));
         for (int i = 0; i < vecs[k].nbits; i++) begin
            tick();
            o = dut_out(d);
            chk($sformatf("vec%0d_bit%0d", k, i), 32'(o[6]), 32'(vecs[k].line[vecs[k].nbits - 1 - i]));
            repeat (C - 1) tick();
         end
         o = dut_out(d);
         chk($sformatf("vec%0d_busy_end", k), 32'(o[4]), 32'(0));
         chk($sformatf("vec%0d_txd_end", k), 32'(o[6]), 32'(1));
         repeat (3) tick();
      end

      // Back-to-back: one frame in flight, then three consecutive writes.
      set_mode(0, 1'b0, 1'b0, 1'b0);
      set_wr(0, 1'b1, 32'h00);
      tick();
      st = cyc;
      set_wr(0, 1'b0, 32'h0);
      repeat (2) tick();
      set_wr(0, 1'b1, 32'h55); tick(); o = dut_out(0); chk("b2b_count1", 32'(o[2:0]), 32'(1));
      set_wr(0, 1'b1, 32'h0F); tick(); o = dut_out(0); chk("b2b_count2", 32'(o[2:0]), 32'(2));
      set_wr(0, 1'b1, 32'hFF); tick(); o = dut_out(0); chk("b2b_count3", 32'(o[2:0]), 32'(3));
      set_wr(0, 1'b0, 32'h0);
      wait_idle(0, st, 4 * 10 * C, "b2b_total_len");
      repeat (2) tick();

      // Mode change during DATA: first frame keeps 8N1, second uses 8E2.
      set_wr(0, 1'b1, 32'h5A);
      tick();
      st = cyc;
      set_wr(0, 1'b0, 32'h0);
      repeat (8) tick();
      set_mode(0, 1'b1, 1'b0, 1'b1);
      set_wr(0, 1'b1, 32'hC3);
      tick();
      set_wr(0, 1'b0, 32'h0);
      wait_idle(0, st, 10 * C + 12 * C, "mode_change_len");
      set_mode(0, 1'b0, 1'b0, 1'b0);
      repeat (2) tick();

      // Overflow: six consecutive writes from idle.
      for (int i = 0; i < 6; i++) begin
         set_wr(0, 1'b1, 32'(8'h10 + i));
         tick();
         if (i == 0) st = cyc;
         if (i == 4) begin
            o = dut_out(0);
            chk("ovf_txrdy_at_full", 32'(o[5]), 32'(0));
            chk("ovf_count_full", 32'(o[2:0]), 32'(4));
            chk("ovf_not_yet", 32'(o[3]), 32'(0));
         end
      end
      set_wr(0, 1'b0, 32'h0);
      o = dut_out(0);
      chk("ovf_overrun_set", 32'(o[3]), 32'(1));
      chk("ovf_count_held", 32'(o[2:0]), 32'(4));
      wait_idle(0, st, 5 * 10 * C, "ovf_five_frames");
      o = dut_out(0);
      chk("ovf_overrun_sticky", 32'(o[3]), 32'(1));

      // Reset mid-frame with two words queued.
      for (int i = 0; i < 3; i++) begin
         set_wr(0, 1'b1, 32'(8'h81 + i));
         tick();
      end
      set_wr(0, 1'b0, 32'h0);
      repeat (6) tick();
      o = dut_out(0);
      chk("rst_pre_count", 32'(o[2:0]), 32'(2));
      rst_n = 1'b0;
      #1;
      o = dut_out(0);
      chk("rst_async_txd", 32'(o[6]), 32'(1));
      chk("rst_async_count", 32'(o[2:0]), 32'(0));
      chk("rst_async_busy", 32'(o[4]), 32'(0));
      chk("rst_async_overrun", 32'(o[3]), 32'(0));
      repeat (2) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         o = dut_out(0);
         chk($sformatf("rst_idle_txd%0d", i), 32'(o[6]), 32'(1));
      end

      // Random traffic and modes on both instances, checked every cycle by the model.
      for (int i = 0; i < 1500; i++) begin
         for (int k = 0; k < 2; k++) begin
            set_mode(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            set_wr(k, ($urandom_range(0, 9) == 0), $urandom);
         end
         tick();
      end
      for (int k = 0; k < 2; k++) set_wr(k, 1'b0, 32'h0);
      for (int i = 0; i < 1000; i++) begin
         if (!b0.Busy && !b1.Busy) break;
         tick();
      end
      chk("final_idle", 32'({b0.Busy, b1.Busy}), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_xmit_gen2.md
# uart_xmit_gen2

Parametrised UART transmitter, the next generation of the UART transmit path in the memory-mapped I/O block. It adds an on-chip baud divider, a small transmit FIFO, and runtime-selectable parity mode and stop-bit count. Character width is set by parameter. It sits behind the UART register decode: the CPU store path drives WR/Din, and TxD goes to the pin.

## Interface
Parameters:
- DATA_BITS, default 8: character width, legal 5..8.
- FIFO_DEPTH, default 4: transmit FIFO entries, power of two, 2..16.
- CLKS_PER_BIT, default 16: Clock cycles per serial bit, ≥2.

Ports:
- Clock  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- WR  in  1  write strobe, one Clock wide per write.
- Din  in  32  write data; only Din[DATA_BITS-1:0] is used.
- ParityEn  in  1  1 = append a parity bit.
- ParityOdd  in  1  1 = odd parity, 0 = even parity; ignored when ParityEn=0.
- TwoStop  in  1  1 = two stop bits, 0 = one stop bit.
- TxRDY  out  1  FIFO not full (count < FIFO_DEPTH).
- Busy  out  1  a frame is in progress or the FIFO is non-empty.
- Overrun  out  1  sticky; set by a WR while the FIFO is full.
- Count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- TxD  out  1  serial output, idle high.

## Operation
- WR=1 with TxRDY=1 pushes Din[DATA_BITS-1:0] into the FIFO.
- WR=1 with TxRDY=0 discards the data and sets Overrun. This holds even when a pop happens on the same edge.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop a word, latch it into the shift register, latch ParityEn/ParityOdd/TwoStop, go to START.
  - START: TxD=0 for one bit period.
  - DATA: TxD = shift[0], LSB first, for DATA_BITS bit periods; shift right at the end of each bit.
  - PARITY: entered only if latched ParityEn=1. TxD = (XOR of data bits) XOR latched ParityOdd.
  - STOP: TxD=1 for 1 bit period, or 2 if latched TwoStop=1. At the end of the last stop period: if the FIFO is non-empty, pop the next word and go straight to START with no idle gap; otherwise go to IDLE.
- Mode inputs are sampled only at the pop. Changes mid-frame do not affect the frame in progress.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps. The bit-end strobe fires when the count is CLKS_PER_BIT-1. The timer is cleared on every pop.
- Bit index counter: 0..DATA_BITS-1 in DATA, and 0..1 in STOP.
- Parity is accumulated serially as bits leave the shift register. It is cleared on pop.
- Frame length is CLKS_PER_BIT × (1 + DATA_BITS + ParityEn + 1 + TwoStop) Clock cycles.
- Simultaneous push and pop with the FIFO non-full: both happen, and Count is unchanged.
- Busy = (state≠IDLE) | (Count≠0).

## Timing
- Reset (async assert, Reset=0) forces:
  - state = IDLE, FIFO empty, Count = 0;
  - TxD = 1, TxRDY = 1, Busy = 0, Overrun = 0;
  - bit timer, bit index and parity accumulator = 0.
- Reset mid-frame aborts immediately: TxD returns high asynchronously and the FIFO contents are lost.
- Reset is released synchronously in effect: the first active edge after deassertion is treated as the first operating cycle.
- TxD is driven from a register and is glitch-free.
- Latency, idle and empty FIFO: WR at edge N → Count=1 after N; pop at edge N+1 → TxD=0 after N+1.
- Count and TxRDY update on the edge following the push or pop.
- TxRDY is combinational from Count.
- Overrun clears only on Reset.

## Structure
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - localparams for the legal DATA_BITS range;
  - a width function for the counters.
- One sub-module: uart_tx_fifo, a synchronous FIFO with push, pop, dout, count, full and empty. It has the same Clock/Reset and is parametrised by width and depth.
- The baud timer, FSM, shift register and parity logic stay in the top module.

## Test plan
- Single character, even parity, one stop: DATA_BITS=8, CLKS_PER_BIT=4, ParityEn=1, ParityOdd=0, TwoStop=0, write 0xA5.
  - TxD per 4-clock bit: 0, 1,0,1,0,0,1,0,1, 0, 1.
  - Frame is 44 clocks; Busy falls after the last stop bit.
- Odd parity, two stop bits, 7-bit mode: DATA_BITS=7, write 0x41.
  - TxD: 0, 1,0,0,0,0,0,1, parity 1, then 1 for 2 bit periods.
  - Din bits [31:7] are ignored.
- Back-to-back frames: write 0x55, 0x0F, 0xFF in three consecutive cycles.
  - Three frames are sent with no idle cycles between the last stop bit and the next start bit.
  - Count steps 1→2→3 and then drains.
- Overflow: with FIFO_DEPTH=4 and the transmitter busy, issue 6 writes.
  - TxRDY drops at Count=4 and Overrun=1.
  - Only the first 5 words are transmitted: 1 popped into the frame plus 4 buffered.
- Mode change mid-frame: toggle ParityEn and TwoStop during DATA.
  - The current frame keeps its latched format; the next frame uses the new settings.
- Reset mid-frame: assert Reset=0 during DATA with 2 words queued.
  - TxD=1, Count=0, Busy=0 immediately.
  - After release, TxD stays high until a new WR.
